// File: rtl/led_ws2812_multichain_pkg.sv
// Shared types and timing constants for the multi-chain WS2812 driver.
// LED_WS2812_MULTICHAIN_RGBW_EN selects 32-bit GRBW pixels instead of 24-bit GRB.
package led_ws2812_pkg;

  typedef enum logic [1:0] {
    RESET_LATCH,
    FETCH,
    SHIFT
  } state_t;

  // Bit cell timing in 400ns ticks
  localparam logic [1:0] T_HIGH1 = 2'd2;
  localparam logic [1:0] T_HIGH0 = 2'd1;
  localparam logic [1:0] T_BIT   = 2'd3;

`ifdef LED_WS2812_MULTICHAIN_RGBW_EN
  localparam int unsigned COLOUR_BITS = 32;
`else
  localparam int unsigned COLOUR_BITS = 24;
`endif

endpackage

// File: rtl/led_ws2812_multichain_if.sv
// Pull interface between the chain driver (master) and the pixel source (slave).
// LED_WS2812_MULTICHAIN_RGBW_EN adds the white colour channel.
interface led_ws2812_multichain_if #(
  parameter int unsigned CHAIN_W = 2,
  parameter int unsigned LED_W   = 8
);
  logic               led_request__ready;
  logic               led_request__first;
  logic [LED_W-1:0]   led_request__led_number;
  logic [CHAIN_W-1:0] led_request__chain;
  logic               led_data__valid;
  logic               led_data__last;
  logic [7:0]         led_data__red;
  logic [7:0]         led_data__green;
  logic [7:0]         led_data__blue;
`ifdef LED_WS2812_MULTICHAIN_RGBW_EN
  logic [7:0]         led_data__white;
`endif

  modport master (
    output led_request__ready, led_request__first,
    output led_request__led_number, led_request__chain,
`ifdef LED_WS2812_MULTICHAIN_RGBW_EN
    input  led_data__white,
`endif
    input  led_data__valid, led_data__last,
    input  led_data__red, led_data__green, led_data__blue
  );

  modport slave (
    input  led_request__ready, led_request__first,
    input  led_request__led_number, led_request__chain,
`ifdef LED_WS2812_MULTICHAIN_RGBW_EN
    output led_data__white,
`endif
    output led_data__valid, led_data__last,
    output led_data__red, led_data__green, led_data__blue
  );
endinterface

// File: rtl/led_ws2812_multichain_tick_gen.sv
// 400ns tick generator: reloads divider_400ns at zero and emits a one-cycle tick.
module led_ws2812_tick_gen (
  input  logic       clk,
  input  logic       clk__enable,
  input  logic       reset,
  input  logic [7:0] divider_400ns,
  output logic       tick
);
  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clk__enable) begin
      if (count == '0) count <= divider_400ns;
      else             count <= count - 8'd1;
    end
  end

  assign tick = clk__enable && (count == '0);
endmodule

// File: rtl/led_ws2812_multichain.sv
// Parallel WS2812 driver: fetches one pixel per live chain, then shifts all chains in lockstep.
// LED_WS2812_MULTICHAIN_RGBW_EN selects 32-bit GRBW pixels.
module led_ws2812_multichain
  import led_ws2812_pkg::*;
#(
  parameter int unsigned NUM_CHAINS  = 4,
  parameter int unsigned MAX_LEDS    = 256,
  parameter int unsigned RESET_TICKS = 150,
  localparam int unsigned CHAIN_W = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1,
  localparam int unsigned LED_W   = (MAX_LEDS > 1) ? $clog2(MAX_LEDS) : 1
) (
  input  logic                     clk,
  input  logic                     clk__enable,
  input  logic                     reset,
  input  logic [7:0]               divider_400ns,
  led_ws2812_multichain_if.master  led,
  output logic [NUM_CHAINS-1:0]    led_chains
);
  localparam int unsigned BIT_W = $clog2(COLOUR_BITS);

  state_t                 state, state_next;
  logic                   tick;
  logic [15:0]            gap_count;
  logic [LED_W-1:0]       led_number;
  logic [CHAIN_W-1:0]     chain;
  logic [NUM_CHAINS-1:0]  done;
  logic [NUM_CHAINS-1:0]  active;
  logic [COLOUR_BITS-1:0] pixel [NUM_CHAINS];
  logic [BIT_W-1:0]       bit_index;
  logic [1:0]             phase;
  logic [COLOUR_BITS-1:0] colour;
  logic                   transfer, gap_done, shift_end, frame_end;
  logic                   next_found;
  logic [CHAIN_W-1:0]     next_chain, open_chain;

  led_ws2812_tick_gen tick_gen (
    .clk           (clk),
    .clk__enable   (clk__enable),
    .reset         (reset),
    .divider_400ns (divider_400ns),
    .tick          (tick)
  );

`ifdef LED_WS2812_MULTICHAIN_RGBW_EN
  assign colour = {led.led_data__green, led.led_data__red, led.led_data__blue, led.led_data__white};
`else
  assign colour = {led.led_data__green, led.led_data__red, led.led_data__blue};
`endif

  assign transfer  = (state == FETCH) && led.led_data__valid && clk__enable;
  assign gap_done  = tick && (gap_count == 16'(RESET_TICKS - 1));
  assign shift_end = tick && (phase == T_BIT - 2'd1) && (bit_index == '0);
  assign frame_end = (&done) || (led_number == LED_W'(MAX_LEDS - 1));

  // Descending scan so the lowest qualifying index wins
  always_comb begin
    next_found = 1'b0;
    next_chain = '0;
    open_chain = '0;
    for (int unsigned i = 0; i < NUM_CHAINS; i++) begin
      if (!done[NUM_CHAINS-1-i] && (CHAIN_W'(NUM_CHAINS-1-i) > chain)) begin
        next_found = 1'b1;
        next_chain = CHAIN_W'(NUM_CHAINS-1-i);
      end
      if (!done[NUM_CHAINS-1-i]) open_chain = CHAIN_W'(NUM_CHAINS-1-i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)            state <= RESET_LATCH;
    else if (clk__enable) state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RESET_LATCH: if (gap_done) state_next = FETCH;
      FETCH:       if (transfer && !next_found) state_next = SHIFT;
      SHIFT:       if (shift_end) state_next = frame_end ? RESET_LATCH : FETCH;
      default:     state_next = RESET_LATCH;
    endcase
  end

  always_comb begin
    led.led_request__ready      = (state == FETCH);
    led.led_request__first      = (state == FETCH) && (led_number == '0) && (chain == '0);
    led.led_request__led_number = led_number;
    led.led_request__chain      = chain;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gap_count  <= '0;
      led_number <= '0;
      chain      <= '0;
      done       <= '0;
      active     <= '0;
      bit_index  <= '0;
      phase      <= '0;
      led_chains <= '0;
      for (int unsigned c = 0; c < NUM_CHAINS; c++) pixel[c] <= '0;
    end else if (clk__enable) begin
      case (state)
        RESET_LATCH: begin
          led_chains <= '0;
          led_number <= '0;
          chain      <= '0;
          done       <= '0;
          active     <= '0;
          bit_index  <= BIT_W'(COLOUR_BITS - 1);
          phase      <= '0;
          if (tick) gap_count <= gap_done ? '0 : gap_count + 16'd1;
        end
        FETCH: begin
          led_chains <= '0;
          bit_index  <= BIT_W'(COLOUR_BITS - 1);
          phase      <= '0;
          if (transfer) begin
            for (int unsigned c = 0; c < NUM_CHAINS; c++) begin
              if (CHAIN_W'(c) == chain) begin
                pixel[c]  <= colour;
                active[c] <= 1'b1;
                done[c]   <= led.led_data__last;
              end
            end
            if (next_found) chain <= next_chain;
          end
        end
        SHIFT: begin
          if (tick) begin
            // Pin level for the tick now starting: high while phase is below the bit's high time
            for (int unsigned c = 0; c < NUM_CHAINS; c++)
              led_chains[c] <= active[c] && (phase < (pixel[c][bit_index] ? T_HIGH1 : T_HIGH0));
            if (phase == T_BIT - 2'd1) begin
              phase <= '0;
              if (bit_index == '0) begin
                active <= '0;
                for (int unsigned c = 0; c < NUM_CHAINS; c++) pixel[c] <= '0;
                if (!frame_end) begin
                  led_number <= led_number + LED_W'(1);
                  chain      <= open_chain;
                end
              end else begin
                bit_index <= bit_index - BIT_W'(1);
              end
            end else begin
              phase <= phase + 2'd1;
            end
          end
        end
        default: led_chains <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_led_ws2812_multichain.sv
// Directed bench for led_ws2812_multichain with two chains, MAX_LEDS=4, divider=1 (tick every 2 clks).
module tb_led_ws2812_multichain;
  import led_ws2812_pkg::*;

  localparam int unsigned BITS = COLOUR_BITS;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b1;
  logic [7:0] div = 8'd1;
  logic [1:0] pins;
  int         checks = 0;
  int         errors = 0;

  led_ws2812_multichain_if #(.CHAIN_W(1), .LED_W(2)) bus ();

  led_ws2812_multichain #(.NUM_CHAINS(2), .MAX_LEDS(4), .RESET_TICKS(150)) dut (
    .clk           (clk),
    .clk__enable   (en),
    .reset         (reset),
    .divider_400ns (div),
    .led           (bus),
    .led_chains    (pins)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pack(input logic [7:0] g, r, b, w);
`ifdef LED_WS2812_MULTICHAIN_RGBW_EN
    return {g, r, b, w};
`else
    return {w & 8'h00, g, r, b};
`endif
  endfunction

  task automatic drive(input logic [31:0] px, input logic last);
`ifdef LED_WS2812_MULTICHAIN_RGBW_EN
    {bus.led_data__green, bus.led_data__red, bus.led_data__blue, bus.led_data__white} = px;
`else
    {bus.led_data__green, bus.led_data__red, bus.led_data__blue} = px[23:0];
`endif
    bus.led_data__last = last;
  endtask

  task automatic wait_ready(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (bus.led_request__ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: ready got 0 required 1 within 1000 clks", name);
    end
  endtask

  task automatic serve(input int exp_chain, input int exp_led, input logic [31:0] px, input logic last);
    bit ok;
    wait_ready($sformatf("serve_ready c%0d l%0d", exp_chain, exp_led), ok);
    if (ok) begin
      checks++;
      if (bus.led_request__chain !== 1'(exp_chain) || bus.led_request__led_number !== 2'(exp_led)) begin
        errors++;
        $display("FAIL serve_fields: chain %0d led %0d required chain %0d led %0d",
                 bus.led_request__chain, bus.led_request__led_number, exp_chain, exp_led);
      end
      drive(px, last);
      bus.led_data__valid = 1'b1;
      @(negedge clk);
      bus.led_data__valid = 1'b0;
    end
  endtask

  // Each bit is 6 clk samples starting at the rising tick edge
  task automatic capture(input string name, input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] act);
    bit seen = 1'b0;
    logic [5:0] s0, s1, x0, x1;
    for (int i = 0; i < 20; i++) begin
      if (pins !== 2'b00) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_start: pins stayed 00, required a rising edge within 20 clks", name);
      return;
    end
    for (int b = BITS - 1; b >= 0; b--) begin
      s0 = '0;
      s1 = '0;
      for (int k = 0; k < 6; k++) begin
        if (!(b == BITS - 1 && k == 0)) @(negedge clk);
        s0 = {s0[4:0], pins[0]};
        s1 = {s1[4:0], pins[1]};
      end
      x0 = act[0] ? (e0[b] ? 6'b111100 : 6'b110000) : 6'b000000;
      x1 = act[1] ? (e1[b] ? 6'b111100 : 6'b110000) : 6'b000000;
      checks++;
      if (s0 !== x0) begin
        errors++;
        $display("FAIL %s chain0 bit%0d: got %b required %b", name, b, s0, x0);
      end
      checks++;
      if (s1 !== x1) begin
        errors++;
        $display("FAIL %s chain1 bit%0d: got %b required %b", name, b, s1, x1);
      end
    end
  endtask

  // Counts clks until ready, flagging any pin activity after 'quiet_from'
  task automatic wait_latch(input string name, input int lo, input int hi, input int quiet_from);
    int  cnt = 0;
    bit  bad = 1'b0;
    while (bus.led_request__ready !== 1'b1 && cnt < hi + 50) begin
      if (cnt >= quiet_from && pins !== 2'b00) bad = 1'b1;
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s_pins: pins active during latch gap, required 00", name);
    end
    checks++;
    if (cnt < lo || cnt > hi) begin
      errors++;
      $display("FAIL %s_len: ready after %0d clks required %0d..%0d", name, cnt, lo, hi);
    end
    checks++;
    if (bus.led_request__first !== 1'b1 || bus.led_request__led_number !== 2'd0 || bus.led_request__chain !== 1'b0) begin
      errors++;
      $display("FAIL %s_first: first %b led %0d chain %0d required 1 0 0", name,
               bus.led_request__first, bus.led_request__led_number, bus.led_request__chain);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (pins !== 2'b00 || bus.led_request__ready !== 1'b0 || bus.led_request__first !== 1'b0 ||
        bus.led_request__led_number !== 2'd0 || bus.led_request__chain !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: pins %b ready %b first %b led %0d chain %0d required all 0", pins,
               bus.led_request__ready, bus.led_request__first, bus.led_request__led_number, bus.led_request__chain);
    end
    reset = 1'b0;
    wait_latch("reset_latch", 295, 305, 0);
  endtask

  task automatic test_shift_pattern();
    serve(0, 0, pack(8'h80, 8'h00, 8'h00, 8'h00), 1'b0);
    serve(1, 0, pack(8'h00, 8'h00, 8'h00, 8'h01), 1'b0);
    capture("pattern", pack(8'h80, 8'h00, 8'h00, 8'h00), pack(8'h00, 8'h00, 8'h00, 8'h01), 2'b11);
  endtask

  task automatic test_stall();
    bit ok;
    bit bad = 1'b0;
    wait_ready("stall_ready", ok);
    for (int i = 0; i < 50; i++) begin
      if (bus.led_request__ready !== 1'b1 || bus.led_request__chain !== 1'b0 ||
          bus.led_request__led_number !== 2'd1 || bus.led_request__first !== 1'b0 || pins !== 2'b00)
        bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL stall_hold: request moved or pins active while valid low, required stable chain0 led1");
    end
    drive(pack(8'hA5, 8'h3C, 8'h0F, 8'hC3), 1'b0);
    bus.led_data__valid = 1'b1;
    @(negedge clk);
    bus.led_data__valid = 1'b0;
    checks++;
    if (bus.led_request__ready !== 1'b1 || bus.led_request__chain !== 1'b1) begin
      errors++;
      $display("FAIL stall_transfer: ready %b chain %0d required 1 1", bus.led_request__ready, bus.led_request__chain);
    end
    serve(1, 1, pack(8'h12, 8'h34, 8'h56, 8'h78), 1'b0);
    capture("stall_data", pack(8'hA5, 8'h3C, 8'h0F, 8'hC3), pack(8'h12, 8'h34, 8'h56, 8'h78), 2'b11);
  endtask

  task automatic test_max_leds();
    serve(0, 2, pack(8'h01, 8'h02, 8'h03, 8'h04), 1'b0);
    serve(1, 2, pack(8'h05, 8'h06, 8'h07, 8'h08), 1'b0);
    capture("led2", pack(8'h01, 8'h02, 8'h03, 8'h04), pack(8'h05, 8'h06, 8'h07, 8'h08), 2'b11);
    serve(0, 3, pack(8'hFF, 8'h00, 8'hFF, 8'h00), 1'b0);
    serve(1, 3, pack(8'h00, 8'hFF, 8'h00, 8'hFF), 1'b0);
    wait_latch("max_leds", 6 * BITS + 290, 6 * BITS + 315, 6 * BITS + 4);
  endtask

  task automatic test_last_skip();
    serve(0, 0, pack(8'hC0, 8'h01, 8'h80, 8'h0F), 1'b0);
    serve(1, 0, pack(8'h3F, 8'hFE, 8'h7F, 8'hF0), 1'b1);
    capture("skip_led0", pack(8'hC0, 8'h01, 8'h80, 8'h0F), pack(8'h3F, 8'hFE, 8'h7F, 8'hF0), 2'b11);
    serve(0, 1, pack(8'h5A, 8'h5A, 8'h5A, 8'h5A), 1'b0);
    checks++;
    if (bus.led_request__ready !== 1'b0) begin
      errors++;
      $display("FAIL skip_led1_req: ready %b chain %0d required ready 0", bus.led_request__ready, bus.led_request__chain);
    end
    capture("skip_led1", pack(8'h5A, 8'h5A, 8'h5A, 8'h5A), 32'h0, 2'b01);
    serve(0, 2, pack(8'h96, 8'h69, 8'h96, 8'h69), 1'b1);
    checks++;
    if (bus.led_request__ready !== 1'b0) begin
      errors++;
      $display("FAIL skip_led2_req: ready %b required 0", bus.led_request__ready);
    end
    capture("skip_led2", pack(8'h96, 8'h69, 8'h96, 8'h69), 32'h0, 2'b01);
    wait_latch("skip_latch", 290, 305, 0);
  endtask

  task automatic test_reset_mid_shift();
    bit seen = 1'b0;
    serve(0, 0, pack(8'hFF, 8'hFF, 8'hFF, 8'hFF), 1'b0);
    serve(1, 0, pack(8'hFF, 8'hFF, 8'hFF, 8'hFF), 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (pins !== 2'b00) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL midreset_start: pins stayed 00, required activity within 20 clks");
    end
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (pins !== 2'b00 || bus.led_request__ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_abort: pins %b ready %b required 00 0", pins, bus.led_request__ready);
    end
    reset = 1'b0;
    wait_latch("midreset_latch", 295, 305, 0);
  endtask

  initial begin
    bus.led_data__valid = 1'b0;
    drive(32'h0, 1'b0);
    test_reset();
    test_shift_pattern();
    test_stall();
    test_max_leds();
    test_last_skip();
    test_reset_mid_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
